// File: rtl/bcd_display_pkg.sv
// Shared types and segment constants for the seven-segment display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package bcd_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

    localparam int unsigned PRESCALE_W = 24;

    function automatic logic [3:0] digit_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_seg_decoder.sv
// Combinational 4-bit code to segment pattern decoder.
// HEX_DIGITS_EN selects hex glyphs for codes 10-15; otherwise they are blank.
module seg_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:  seg = SEG_0;
            4'd1:  seg = SEG_1;
            4'd2:  seg = SEG_2;
            4'd3:  seg = SEG_3;
            4'd4:  seg = SEG_4;
            4'd5:  seg = SEG_5;
            4'd6:  seg = SEG_6;
            4'd7:  seg = SEG_7;
            4'd8:  seg = SEG_8;
            4'd9:  seg = SEG_9;
`ifdef HEX_DIGITS_EN
            4'd10: seg = SEG_A;
            4'd11: seg = SEG_B;
            4'd12: seg = SEG_C;
            4'd13: seg = SEG_D;
            4'd14: seg = SEG_E;
            4'd15: seg = SEG_F;
`else
            4'd10, 4'd11, 4'd12,
            4'd13, 4'd14, 4'd15: seg = SEG_BLANK;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit seven-segment driver with programmable scan rate.
// Optional HEX_DIGITS_EN macro enables A-F glyphs in the segment decoder.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 3_333_333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [6:0]  seg,
    output logic [6:0]  seg_n,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel
);

    localparam logic [PRESCALE_W-1:0] TERM_COUNT = PRESCALE_W'(SCAN_DIV - 1);

    logic [PRESCALE_W-1:0] prescale;
    logic                  step;
    logic [3:0]            nibble;
    seg_t                  seg_next;

    assign step = (prescale == TERM_COUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
        end else if (step) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_sel <= '0;
        end else if (step) begin
            digit_sel <= digit_sel + 2'd1;
        end
    end

    always_comb begin
        nibble = value[3:0];
        case (digit_sel)
            2'd0: nibble = value[3:0];
            2'd1: nibble = value[7:4];
            2'd2: nibble = value[11:8];
            2'd3: nibble = value[15:12];
            default: nibble = value[3:0];
        endcase
    end

    seg_decoder u_seg_decoder (
        .code (nibble),
        .seg  (seg_next)
    );

    // Enable and pattern are both sampled from the pre-edge digit_sel, so they always match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an    <= '0;
            seg   <= '0;
            seg_n <= '1;
        end else begin
            an    <= digit_onehot(digit_sel);
            seg   <= seg_next;
            seg_n <= ~seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner at SCAN_DIV = 4, 1 and 8.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;

    logic [6:0]  seg_o   [3];
    logic [6:0]  seg_n_o [3];
    logic [3:0]  an_o    [3];
    logic [1:0]  sel_o   [3];

    always #5 clk = ~clk;

    bcd_display_scanner #(.SCAN_DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .value(value),
        .seg(seg_o[0]), .seg_n(seg_n_o[0]), .an(an_o[0]), .digit_sel(sel_o[0])
    );
    bcd_display_scanner #(.SCAN_DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .value(value),
        .seg(seg_o[1]), .seg_n(seg_n_o[1]), .an(an_o[1]), .digit_sel(sel_o[1])
    );
    bcd_display_scanner #(.SCAN_DIV(8)) u_div8 (
        .clk(clk), .reset(reset), .value(value),
        .seg(seg_o[2]), .seg_n(seg_n_o[2]), .an(an_o[2]), .digit_sel(sel_o[2])
    );

    typedef struct {
        int unsigned k;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [6:0]  seg_n;
        logic [1:0]  sel;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned div_of [3] = '{4, 1, 8};
    string       names  [3] = '{"div4", "div1", "div8"};
    int unsigned cnt    [3];
    logic [1:0]  msel   [3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
`ifdef HEX_DIGITS_EN
            4'd10: return 7'h77;
            4'd11: return 7'h7C;
            4'd12: return 7'h39;
            4'd13: return 7'h5E;
            4'd14: return 7'h79;
            4'd15: return 7'h71;
`endif
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k]  = 0;
            msel[k] = 2'd0;
        end
    endtask

    task automatic push_dark();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.k = k; e.an = 4'b0000; e.seg = 7'h00; e.seg_n = 7'h7F; e.sel = 2'd0;
            sb.push_back(e);
        end
    endtask

    // Expected outputs after the coming rising edge, given current inputs and model state.
    task automatic push_cycle();
        exp_t        e;
        logic [15:0] v;
        logic [6:0]  s;
        if (reset !== 1'b1) begin
            model_reset();
            push_dark();
        end else begin
            for (int k = 0; k < 3; k++) begin
                v = value >> (4 * msel[k]);
                s = ref_seg(v[3:0]);
                e.k = k;
                e.an = 4'b0001 << msel[k];
                e.seg = s;
                e.seg_n = ~s;
                if (cnt[k] == div_of[k] - 1) begin
                    cnt[k]  = 0;
                    msel[k] = msel[k] + 2'd1;
                end else begin
                    cnt[k] = cnt[k] + 1;
                end
                e.sel = msel[k];
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({names[e.k], ".an"},        32'(an_o[e.k]),    32'(e.an));
            check_eq({names[e.k], ".seg"},       32'(seg_o[e.k]),   32'(e.seg));
            check_eq({names[e.k], ".seg_n"},     32'(seg_n_o[e.k]), 32'(e.seg_n));
            check_eq({names[e.k], ".digit_sel"}, 32'(sel_o[e.k]),   32'(e.sel));
        end
    endtask

    task automatic cycle();
        push_cycle();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic run(input int unsigned n);
        repeat (n) cycle();
    endtask

    initial begin
        int unsigned guard;
        reset = 1'b0;
        value = 16'h1234;
        model_reset();

        // Held in reset: display dark.
        run(5);

        // Scan order.
        value = 16'h4321;
        reset = 1'b1;
        run(20);

        // Decode sweep 0-9 on every digit.
        for (int n = 0; n < 10; n++) begin
            value = {4{4'(n)}};
            run(4);
        end

        // Non-BCD codes.
        value = 16'hFEDC;
        run(8);

        // Live update while digit 1 is active on the SCAN_DIV=8 instance.
        value = 16'h0020;
        guard = 0;
        while (!(msel[2] == 2'd1 && cnt[2] == 2) && guard < 64) begin
            cycle();
            guard++;
        end
        if (guard >= 64) check_eq("live_wait_timeout", 32'd0, 32'd1);
        value = 16'h0090;
        run(3);

        // Mid-scan reset while the SCAN_DIV=4 instance drives digit 2.
        value = 16'h5678;
        guard = 0;
        while (msel[0] != 2'd2 && guard < 64) begin
            cycle();
            guard++;
        end
        if (guard >= 64) check_eq("reset_wait_timeout", 32'd0, 32'd1);
        #2;
        reset = 1'b0;
        model_reset();
        push_dark();
        #1;
        drain();
        run(3);
        reset = 1'b1;
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
